ram_readout: RTL

- Reader side of the 256-word dump RAM page shared with the FPGA-side dump writer.
- Detects a pending frame through the FPGA/PC toggle handshake and reads all 256 32-bit words from the RAM read port.
- Serialises each word into 4 bytes on a valid/ready byte stream, in the original channel byte order, for local readout or loopback.
- Returns the page to the writer by toggling handshakePC.

---
 rtl/ram_readout_pkg.sv | 22 ++
 rtl/ram_readout_word_serializer.sv | 53 +++++
 rtl/ram_readout.sv | 116 +++++++++++
 3 files changed

// File: rtl/ram_readout_pkg.sv
// Shared types and constants for the dump-page reader.
// Included by the reader top and its word serialiser.
package ram_readout_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DEF_ADDR_W     = 8;
   localparam int PAGE_WORDS     = 1 << DEF_ADDR_W;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;

   function automatic int page_words(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/ram_readout_word_serializer.sv
// Holds one RAM word and presents it MSB byte first on a
// valid/ready byte stream; done pulses on the last byte's transfer.
module word_serializer
   import ram_readout_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   input  logic              ready,
   output logic [7:0]        data,
   output logic              valid,
   output logic [1:0]        index,
   output logic              done
);

   logic [WORD_W-1:0] word_q;
   logic [1:0]        idx_q;
   logic              valid_q;

   assign valid = valid_q;
   assign index = idx_q;
   assign done  = valid_q && ready
                  && (idx_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= word;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && ready) begin
         idx_q <= idx_q + 2'd1;
         if (done) valid_q <= 1'b0;
      end
   end

   // channel arrival order: MSB byte goes out first
   always_comb begin
      data = word_q[31:24];
      unique case (idx_q)
         2'd0: data = word_q[31:24];
         2'd1: data = word_q[23:16];
         2'd2: data = word_q[15:8];
         2'd3: data = word_q[7:0];
         default: data = word_q[31:24];
      endcase
   end

endmodule

// File: rtl/ram_readout.sv
// Reader side of the shared dump page: waits for the writer's toggle,
// streams every word out as bytes, then hands the page back.
module ram_readout
   import ram_readout_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic              SYSCLK,
   input  logic              reset,
   input  logic              enable,
   input  logic              handshakeFPGA,
   output logic              handshakePC,
   output logic [ADDR_W-1:0] RAM_rd_addr,
   output logic              RAM_rd_en,
   input  logic [WORD_W-1:0] RAM_rd_data,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_first,
   output logic              byte_last,
   output logic              busy,
   output logic [15:0]       frames_read
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        lat_cnt;
   logic              load, advance, finish;
   logic              ser_done;
   logic [1:0]        ser_index;
   logic              last_addr;

   assign last_addr = (addr == {ADDR_W{1'b1}});

   word_serializer u_ser (
      .clk   (SYSCLK),
      .rst   (reset),
      .load  (load),
      .word  (RAM_rd_data),
      .ready (byte_ready),
      .data  (byte_data),
      .valid (byte_valid),
      .index (ser_index),
      .done  (ser_done)
   );

   always_ff @(posedge SYSCLK or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         addr        <= '0;
         lat_cnt     <= '0;
         handshakePC <= 1'b0;
         frames_read <= '0;
      end else begin
         state   <= state_n;
         lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
         if (advance) addr <= addr + 1'b1;
         if (finish) begin
            addr        <= '0;
            handshakePC <= ~handshakePC;
            frames_read <= frames_read + 16'd1;
         end
      end
   end

   // pending is only looked at from IDLE, so writer toggles mid-frame are ignored
   always_comb begin
      state_n   = state;
      RAM_rd_en = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && (handshakeFPGA != handshakePC))
               state_n = FETCH;
         end
         FETCH: begin
            RAM_rd_en = 1'b1;
            state_n   = WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_LAST) begin
               load    = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            if (ser_done) begin
               if (last_addr) begin
                  state_n = DONE;
               end else begin
                  advance = 1'b1;
                  state_n = FETCH;
               end
            end
         end
         DONE: begin
            finish  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign RAM_rd_addr = addr;
   assign busy        = (state != IDLE);
   assign byte_first  = (state == SEND) && (addr == '0)
                        && (ser_index == 2'd0);
   assign byte_last   = (state == SEND) && last_addr
                        && (ser_index == 2'd3);

endmodule
